// File: rtl/panda_srgate_multi.sv
// panda_srgate_multi
// Multi-channel set/reset gate for the PandA bit bus. Each channel is an
// independent SR latch driven by edge-detected set/reset inputs, register
// force strobes and an optional shared auto-clear timeout.

module panda_srgate_multi #(
    parameter int NCH = 4,
    parameter int TW  = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [NCH-1:0]    set_i,
    input  logic [NCH-1:0]    rst_i,
    input  logic [2*NCH-1:0]  SET_EDGE,
    input  logic [2*NCH-1:0]  RESET_EDGE,
    input  logic [NCH-1:0]    PRIORITY,
    input  logic [NCH-1:0]    FORCE_SET,
    input  logic [NCH-1:0]    FORCE_RESET,
    input  logic [TW-1:0]     TIMEOUT,
    output logic [NCH-1:0]    out_o,
    output logic [NCH-1:0]    timeout_o
);

    localparam logic [1:0]    EDGE_FALL = 2'd1;
    localparam logic [1:0]    EDGE_BOTH = 2'd2;
    localparam logic [TW-1:0] CNT_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_MAX   = {TW{1'b1}};

    // Edge event for one input bit; mode 3 falls back to rising.
    function automatic logic edge_event(input logic [1:0] mode,
                                        input logic       cur,
                                        input logic       prev);
        logic ev;
        case (mode)
            EDGE_FALL: ev = ~cur & prev;
            EDGE_BOTH: ev = cur ^ prev;
            default:   ev = cur & ~prev;
        endcase
        return ev;
    endfunction

    // Saturating increment: a long-high channel with expiry disabled must
    // never wrap back into the expiry window.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] cnt);
        logic [TW-1:0] nxt;
        if (cnt == CNT_MAX)
            nxt = cnt;
        else
            nxt = cnt + CNT_ONE;
        return nxt;
    endfunction

    logic          primed;
    logic          tmo_en;
    logic [TW-1:0] tmo_lim;

    // The counter holds (cycles high - 1) at each clock edge, so expiry
    // fires when it reaches TIMEOUT-1. Only meaningful when TIMEOUT != 0.
    assign tmo_en  = (TIMEOUT != '0);
    assign tmo_lim = TIMEOUT - CNT_ONE;

    // Priming flag: the first clock after reset release only loads the
    // previous-sample registers so a level already high is not an edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            primed <= 1'b0;
        else
            primed <= 1'b1;
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic          set_prev;
        logic          rst_prev;
        logic [TW-1:0] cnt;
        logic          set_ev;
        logic          rst_ev;
        logic          tmo;
        logic          set_win;
        logic          rst_win;

        // Event detection and resolution: forces mask edges and timeout;
        // PRIORITY arbitrates simultaneous set/reset of the same class.
        always_comb begin
            set_ev  = primed & edge_event(SET_EDGE[2*ch +: 2], set_i[ch], set_prev);
            rst_ev  = primed & edge_event(RESET_EDGE[2*ch +: 2], rst_i[ch], rst_prev);
            tmo     = out_o[ch] & tmo_en & (cnt >= tmo_lim);
            set_win = 1'b0;
            rst_win = 1'b0;
            if (FORCE_SET[ch] | FORCE_RESET[ch]) begin
                set_win = FORCE_SET[ch] & (~FORCE_RESET[ch] | PRIORITY[ch]);
                rst_win = FORCE_RESET[ch] & ~set_win;
            end else begin
                set_win = set_ev & (~rst_ev | PRIORITY[ch]);
                rst_win = rst_ev & ~set_win;
            end
        end

        // Previous-sample registers track the raw inputs every cycle.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                set_prev <= 1'b0;
                rst_prev <= 1'b0;
            end else begin
                set_prev <= set_i[ch];
                rst_prev <= rst_i[ch];
            end
        end

        // Latch, timeout counter and expiry pulse. A set retriggers the
        // counter; a reset on the expiry cycle suppresses the pulse.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                out_o[ch]     <= 1'b0;
                timeout_o[ch] <= 1'b0;
                cnt           <= '0;
            end else begin
                timeout_o[ch] <= 1'b0;
                if (set_win) begin
                    out_o[ch] <= 1'b1;
                    cnt       <= '0;
                end else if (rst_win) begin
                    out_o[ch] <= 1'b0;
                    cnt       <= '0;
                end else if (tmo) begin
                    out_o[ch]     <= 1'b0;
                    timeout_o[ch] <= 1'b1;
                    cnt           <= '0;
                end else if (out_o[ch]) begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_panda_srgate_multi.sv
// Testbench for panda_srgate_multi: directed scenarios followed by a
// randomized phase, all checked against a cycle-count reference model.

module tb_panda_srgate_multi;

    localparam int NCH = 4;
    localparam int TW  = 32;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [NCH-1:0]    set_i;
    logic [NCH-1:0]    rst_i;
    logic [2*NCH-1:0]  SET_EDGE;
    logic [2*NCH-1:0]  RESET_EDGE;
    logic [NCH-1:0]    PRIORITY;
    logic [NCH-1:0]    FORCE_SET;
    logic [NCH-1:0]    FORCE_RESET;
    logic [TW-1:0]     TIMEOUT;
    logic [NCH-1:0]    out_o;
    logic [NCH-1:0]    timeout_o;

    int n_cmp  = 0;
    int n_fail = 0;

    panda_srgate_multi #(.NCH(NCH), .TW(TW)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .set_i       (set_i),
        .rst_i       (rst_i),
        .SET_EDGE    (SET_EDGE),
        .RESET_EDGE  (RESET_EDGE),
        .PRIORITY    (PRIORITY),
        .FORCE_SET   (FORCE_SET),
        .FORCE_RESET (FORCE_RESET),
        .TIMEOUT     (TIMEOUT),
        .out_o       (out_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: latch state, the cycle number at which each channel
    // was last set, and the last sampled input levels.
    bit m_out [NCH];
    bit m_tout[NCH];
    int m_start[NCH];
    bit m_sp  [NCH];
    bit m_rp  [NCH];
    bit m_primed;
    int cyc;

    function automatic bit is_event(logic [1:0] mode, bit cur, bit prev);
        if (mode == 2'd1) return !cur && prev;
        if (mode == 2'd2) return cur != prev;
        return cur && !prev;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_out[c] = 0; m_tout[c] = 0; m_start[c] = 0; m_sp[c] = 0; m_rp[c] = 0;
        end
        m_primed = 0;
    endtask

    task automatic model_step();
        bit sev, rev, fs, fr, pr, expired, do_set, do_clr;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            sev = m_primed && is_event(SET_EDGE[2*c +: 2], set_i[c], m_sp[c]);
            rev = m_primed && is_event(RESET_EDGE[2*c +: 2], rst_i[c], m_rp[c]);
            fs = FORCE_SET[c]; fr = FORCE_RESET[c]; pr = PRIORITY[c];
            expired = m_out[c] && (TIMEOUT != 0) && ((cyc - m_start[c]) >= int'(TIMEOUT));
            if (fs || fr) begin
                do_set = fs && (!fr || pr);
                do_clr = fr && !do_set;
            end else begin
                do_set = sev && (!rev || pr);
                do_clr = rev && !do_set;
            end
            m_tout[c] = 0;
            if (do_set) begin
                m_out[c] = 1; m_start[c] = cyc;
            end else if (do_clr) begin
                m_out[c] = 0;
            end else if (expired) begin
                m_out[c] = 0; m_tout[c] = 1;
            end
            m_sp[c] = set_i[c];
            m_rp[c] = rst_i[c];
        end
        m_primed = 1;
    endtask

    task automatic chk(string tag, logic [NCH-1:0] obs, logic [NCH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_model(string tag);
        logic [NCH-1:0] eo, et;
        for (int c = 0; c < NCH; c++) begin
            eo[c] = m_out[c];
            et[c] = m_tout[c];
        end
        chk({tag, ".out"}, out_o, eo);
        chk({tag, ".tmo"}, timeout_o, et);
    endtask

    // One clock: model consumes the inputs present at the edge, outputs
    // are sampled 1 time unit later; force strobes are then dropped.
    task automatic tick(string tag);
        @(posedge clk_i);
        if (reset_n_i) model_step();
        #1;
        chk_model(tag);
        FORCE_SET   = '0;
        FORCE_RESET = '0;
    endtask

    initial begin
        reset_n_i = 1'b0;
        set_i = '0; rst_i = '0;
        SET_EDGE = '0; RESET_EDGE = '0; PRIORITY = '0;
        FORCE_SET = '0; FORCE_RESET = '0; TIMEOUT = '0;
        cyc = 0;
        model_reset();

        // Reset state, with set_i held high across release.
        #3;
        set_i = 4'b1111;
        #9;
        chk("reset.out", out_o, 4'b0000);
        chk("reset.tmo", timeout_o, 4'b0000);
        reset_n_i = 1'b1;
        tick("prime");
        chk("prime.no_event", out_o, 4'b0000);
        tick("held_high");
        chk("held_high.no_event", out_o, 4'b0000);
        set_i = '0;
        tick("drop");

        // ch0 rising set then rising reset.
        set_i[0] = 1'b1;
        tick("ch0_set");
        chk("ch0_set.direct", out_o, 4'b0001);
        tick("ch0_hold");
        rst_i[0] = 1'b1;
        tick("ch0_rst");
        chk("ch0_rst.direct", out_o, 4'b0000);
        set_i[0] = 1'b0; rst_i[0] = 1'b0;
        tick("ch0_idle");

        // ch1 falling-edge set, both-edge reset.
        SET_EDGE[3:2] = 2'd1; RESET_EDGE[3:2] = 2'd2;
        set_i[1] = 1'b1;
        tick("ch1_rise");
        chk("ch1_rise.ignored", out_o, 4'b0000);
        set_i[1] = 1'b0;
        tick("ch1_fall");
        chk("ch1_fall.set", out_o, 4'b0010);
        rst_i[1] = 1'b1;
        tick("ch1_rst");
        chk("ch1_rst.clear", out_o, 4'b0000);
        rst_i[1] = 1'b0;
        tick("ch1_rst_fall");

        // ch2 simultaneous set/reset under both priorities.
        set_i[2] = 1'b1; rst_i[2] = 1'b1;
        tick("ch2_p0");
        chk("ch2_p0.reset_wins", out_o, 4'b0000);
        set_i[2] = 1'b0; rst_i[2] = 1'b0;
        tick("ch2_low");
        PRIORITY[2] = 1'b1;
        set_i[2] = 1'b1; rst_i[2] = 1'b1;
        tick("ch2_p1");
        chk("ch2_p1.set_wins", out_o, 4'b0100);
        set_i[2] = 1'b0; rst_i[2] = 1'b0;
        FORCE_RESET[2] = 1'b1;
        tick("ch2_frc_clr");

        // ch3 timeout of 5, plain then retriggered.
        TIMEOUT = 32'd5;
        set_i[3] = 1'b1;
        tick("ch3_set");
        set_i[3] = 1'b0;
        for (int i = 0; i < 4; i++) tick("ch3_high");
        chk("ch3_high.direct", out_o, 4'b1000);
        tick("ch3_expire");
        chk("ch3_expire.tmo", timeout_o, 4'b1000);
        chk("ch3_expire.out", out_o, 4'b0000);
        tick("ch3_after");
        set_i[3] = 1'b1;
        tick("ch3_set2");
        set_i[3] = 1'b0;
        tick("ch3_h1"); tick("ch3_h2");
        set_i[3] = 1'b1;
        tick("ch3_retrig");
        set_i[3] = 1'b0;
        for (int i = 0; i < 4; i++) tick("ch3_rhigh");
        tick("ch3_rexpire");
        chk("ch3_rexpire.tmo", timeout_o, 4'b1000);
        TIMEOUT = '0;

        // Force set beats a rising reset edge; forces together, PRIORITY=0.
        FORCE_SET[0] = 1'b1; rst_i[0] = 1'b1;
        tick("force_vs_edge");
        chk("force_vs_edge.direct", out_o[0], 1'b1);
        rst_i[0] = 1'b0;
        FORCE_SET[0] = 1'b1; FORCE_RESET[0] = 1'b1;
        tick("force_both");
        chk("force_both.direct", out_o[0], 1'b0);

        // Asynchronous reset in the middle of a timed pulse.
        TIMEOUT = 32'd3;
        set_i[0] = 1'b1;
        tick("async_set");
        set_i[0] = 1'b0;
        tick("async_high");
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_reset.out", out_o, 4'b0000);
        chk("async_reset.tmo", timeout_o, 4'b0000);
        model_reset();
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;
        tick("rel_prime");
        set_i[0] = 1'b1;
        tick("post_set");
        set_i[0] = 1'b0;
        tick("post_h1"); tick("post_h2");
        tick("post_expire");
        chk("post_expire.tmo", timeout_o, 4'b0001);

        // Randomized phase, including live TIMEOUT and mode changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                SET_EDGE   = (2*NCH)'($urandom);
                RESET_EDGE = (2*NCH)'($urandom);
                PRIORITY   = NCH'($urandom);
            end
            if ($urandom_range(0, 25) == 0)
                TIMEOUT = 32'($urandom_range(0, 7));
            set_i = set_i ^ (NCH'($urandom) & NCH'($urandom));
            rst_i = rst_i ^ (NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
            if ($urandom_range(0, 9) == 0) FORCE_SET   = NCH'($urandom);
            if ($urandom_range(0, 9) == 0) FORCE_RESET = NCH'($urandom);
            if (i == 300) begin
                #2;
                reset_n_i = 1'b0;
                #1;
                chk("rand_async.out", out_o, 4'b0000);
                model_reset();
                #3;
                reset_n_i = 1'b1;
            end
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/panda_srgate_multi.md
# panda_srgate_multi

Parametrised multi-channel successor to the single-channel set/reset gate. Holds NCH independent SR latches, each with per-channel edge-mode selection (rising/falling/both) for set and reset inputs, configurable priority on simultaneous events, force-set/force-reset register strobes and an optional auto-clear timeout. Sits in the PandA position-bus/bit-bus block layer, with inputs from the bit bus, registers from the block register interface and outputs back to the bit bus.

## Interface
- NCH, 4, number of independent channels (1..32)
- TW, 32, width of the timeout register and per-channel counter

- clk_i  in  1  system clock, all logic on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- set_i  in  NCH  per-channel set input (bit bus)
- rst_i  in  NCH  per-channel reset input (bit bus)
- SET_EDGE  in  2*NCH  per-channel set edge mode: 0 rising, 1 falling, 2 both, 3 treated as rising
- RESET_EDGE  in  2*NCH  per-channel reset edge mode, same encoding
- PRIORITY  in  NCH  per-channel: 0 reset wins, 1 set wins on simultaneous events
- FORCE_SET  in  NCH  per-channel one-cycle write strobe
- FORCE_RESET  in  NCH  per-channel one-cycle write strobe
- TIMEOUT  in  TW  auto-clear length in clk_i cycles, shared by all channels; 0 disables
- out_o  out  NCH  latched gate output per channel
- timeout_o  out  NCH  one-cycle pulse per channel when timeout clears out_o

## Operation
- Per channel: previous-sample registers set_prev, rst_prev; event = edge per mode, computed from current input vs previous sample.
- Rising: in & ~prev. Falling: ~in & prev. Both: in ^ prev.
- Priming: after reset release the first active clock only loads set_prev/rst_prev; no edge is detected on that cycle (input high at release is not an event).
- Candidate events per channel each cycle: force_set, force_reset, set_ev, rst_ev, tmo (timeout expiry).
- Resolution order:
  - Any force strobe present: input edges and tmo ignored. Both force strobes: PRIORITY decides.
  - Otherwise set_ev and rst_ev both: PRIORITY decides.
  - Set event (force or edge) while out_o=1: out_o stays 1, timeout counter restarts (retrigger).
  - tmo and winning set event same cycle: set wins, counter restarts, timeout_o stays 0.
  - tmo and reset event same cycle: out_o cleared, timeout_o stays 0 (cleared by reset, not timeout).
- Timeout counter: cleared to 0 on every set event; increments each cycle out_o=1; when TIMEOUT!=0 and out_o has been high for TIMEOUT cycles, tmo asserts -> out_o clears, timeout_o pulses for one cycle.
- TIMEOUT compared live; if written to a value <= current count while high, expiry occurs on the next cycle. Writing 0 while high disables expiry, counter saturates at all-ones, no wrap.
- Edge-mode and PRIORITY changes take effect the cycle they are presented; prev registers unaffected.
- Channels fully independent; no cross-channel interaction.

## Timing
- Reset (reset_n_i=0, asynchronous): out_o=0, timeout_o=0, counters=0, prev registers=0, priming flag cleared. Reset mid-operation clears immediately, without waiting for clk_i.
- Latency: input edge or force strobe sampled at clk edge k -> out_o updated after edge k (one register stage, no extra pipelining).
- Timeout: set event at edge k -> out_o high from k; with TIMEOUT=T, out_o low and timeout_o high after edge k+T; timeout_o low again after k+T+1. Pulse width of out_o is exactly T cycles.
- Input pulses of one cycle are detected in every mode; a one-cycle high pulse in "both" mode yields two events (set on rise and on fall).

## Test plan
- NCH=4, TIMEOUT=0, ch0 SET_EDGE=0 RESET_EDGE=0: set_i rises at ts 10, rst_i rises at ts 20 -> out_o[0]=1 from ts 10 to 19, 0 from ts 20; other channels 0.
- ch1 SET_EDGE=1, RESET_EDGE=2: set_i 1 at ts 5, 0 at ts 8; rst_i 1 at ts 12 -> out_o[1] rises at ts 8, falls at ts 12.
- ch2 set_i and rst_i rise together at ts 30: PRIORITY=0 -> out_o[2] stays 0; repeat with PRIORITY=1 -> out_o[2]=1 at ts 30.
- ch3 TIMEOUT=5: set edge ts 40 -> out_o[3] high ts 40-44, low at 45, timeout_o[3]=1 only at 45; retrigger at ts 43 -> high until 47, pulse at 48.
- FORCE_SET and rst_i rising edge same cycle (ts 50) -> out_o=1; FORCE_SET and FORCE_RESET same cycle with PRIORITY=0 -> out_o=0.
- Hold set_i=1 through reset release -> no set event on priming cycle, out_o=0; assert reset_n_i=0 mid-pulse with out_o=1 -> out_o=0 immediately, counter cleared.
